// File: rtl/div_iter_multi.sv
// div_iter_multi -- iterative restoring integer divider for the execute stage.
//
// Retires STEP quotient bits per cycle over WIDTH/STEP iterations, then
// applies the signed fix-up to quotient and remainder. Operands and mode
// are captured when a start is accepted in FREE, so the requester may change
// its inputs afterwards. Divide-by-zero takes a short path that reports a
// zero result with div_by_zero_out set.
//
// Parameters:
//   WIDTH  operand width (>= 4, multiple of STEP)
//   STEP   quotient bits retired per cycle (1, 2 or 4)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   signed_div_in     1 = signed division (sampled at start)
//   opdata1_in        dividend (sampled at start)
//   opdata2_in        divisor (sampled at start)
//   start_in          request, held high until the result is consumed
//   annul_in          abort a request or an in-flight division
//   result_out        {remainder, quotient}
//   ready_out         result valid
//   busy_out          division in progress (ON or FIX)
//   div_by_zero_out   qualifies result_out when ready_out is high
module div_iter_multi #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_in,
    input  logic [WIDTH-1:0]   opdata1_in,
    input  logic [WIDTH-1:0]   opdata2_in,
    input  logic               start_in,
    input  logic               annul_in,
    output logic [2*WIDTH-1:0] result_out,
    output logic               ready_out,
    output logic               busy_out,
    output logic               div_by_zero_out
);

    localparam int K  = WIDTH / STEP;
    localparam int CW = $clog2(K + 1);

    typedef enum logic [2:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_FIX,
        S_END
    } state_e;

    state_e             state_q;
    logic               sgn_q;      // signed mode captured at start
    logic               neg_a_q;    // dividend MSB captured at start
    logic               neg_b_q;    // divisor MSB captured at start
    logic [WIDTH-1:0]   quo_q;      // dividend magnitude, shifted out as quotient shifts in
    logic [WIDTH-1:0]   rem_q;      // partial remainder
    logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
    logic [CW-1:0]      cnt_q;
    logic               flag_q;     // divide-by-zero seen for this request
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;
    logic               dbz_q;

    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Operand magnitudes for capture in FREE.
    always_comb begin
        mag_a = (signed_div_in && opdata1_in[WIDTH-1]) ? -opdata1_in : opdata1_in;
        mag_b = (signed_div_in && opdata2_in[WIDTH-1]) ? -opdata2_in : opdata2_in;
    end

    // STEP chained restoring steps. The remainder stays below the divisor,
    // so the (WIDTH+1)-bit shifted value minus the divisor always fits in
    // WIDTH bits when the trial succeeds.
    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        shifted = '0;
        for (int i = 0; i < STEP; i++) begin
            shifted = {rem_d, quo_d[WIDTH-1]};
            quo_d   = {quo_d[WIDTH-2:0], 1'b0};
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d    = shifted[WIDTH-1:0] - dvs_q;
                quo_d[0] = 1'b1;
            end else begin
                rem_d = shifted[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_FREE: begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    dbz_q    <= 1'b0;
                    flag_q   <= 1'b0;
                    if (start_in && !annul_in) begin
                        sgn_q   <= signed_div_in;
                        neg_a_q <= opdata1_in[WIDTH-1];
                        neg_b_q <= opdata2_in[WIDTH-1];
                        if (opdata2_in == '0) begin
                            state_q <= S_BYZERO;
                        end else begin
                            quo_q   <= mag_a;
                            dvs_q   <= mag_b;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_ON;
                        end
                    end
                end
                S_BYZERO: begin
                    quo_q   <= '0;
                    rem_q   <= '0;
                    flag_q  <= 1'b1;
                    state_q <= S_END;
                end
                S_ON: begin
                    if (annul_in) begin
                        state_q <= S_FREE;
                    end else begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(K - 1))
                            state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (annul_in) begin
                        state_q <= S_FREE;
                    end else begin
                        // MIN / -1 falls out naturally: magnitude 2^(W-1)
                        // negated is MIN again, remainder 0.
                        if (sgn_q && (neg_a_q ^ neg_b_q))
                            quo_q <= -quo_q;
                        if (sgn_q && neg_a_q)
                            rem_q <= -rem_q;
                        state_q <= S_END;
                    end
                end
                S_END: begin
                    // Result is held while the requester keeps start high;
                    // dropping start releases the block back to FREE.
                    if (start_in) begin
                        result_q <= {rem_q, quo_q};
                        ready_q  <= 1'b1;
                        dbz_q    <= flag_q;
                    end else begin
                        result_q <= '0;
                        ready_q  <= 1'b0;
                        dbz_q    <= 1'b0;
                        flag_q   <= 1'b0;
                        state_q  <= S_FREE;
                    end
                end
                default: state_q <= S_FREE;
            endcase
        end
    end

    assign result_out      = result_q;
    assign ready_out       = ready_q;
    assign div_by_zero_out = dbz_q;
    assign busy_out        = (state_q == S_ON) || (state_q == S_FIX);

endmodule

// File: tb/tb_div_iter_multi.sv
// Scoreboarded bench for div_iter_multi: three instances (32/1, 16/2, 32/4)
// share clock and reset. The driver pushes expected results; a negedge
// monitor pops and compares on each rising ready_out.
module tb_div_iter_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sgn [3];
    logic        st  [3];
    logic        an  [3];
    logic [31:0] op1 [3];
    logic [31:0] op2 [3];

    logic [63:0] res0, res2;
    logic [31:0] res1;
    logic        rdy0, rdy1, rdy2, bsy0, bsy1, bsy2, dbz0, dbz1, dbz2;

    div_iter_multi #(.WIDTH(32), .STEP(1)) u0 (
        .clk(clk), .rst(rst), .signed_div_in(sgn[0]), .opdata1_in(op1[0]),
        .opdata2_in(op2[0]), .start_in(st[0]), .annul_in(an[0]), .result_out(res0),
        .ready_out(rdy0), .busy_out(bsy0), .div_by_zero_out(dbz0));
    div_iter_multi #(.WIDTH(16), .STEP(2)) u1 (
        .clk(clk), .rst(rst), .signed_div_in(sgn[1]), .opdata1_in(op1[1][15:0]),
        .opdata2_in(op2[1][15:0]), .start_in(st[1]), .annul_in(an[1]), .result_out(res1),
        .ready_out(rdy1), .busy_out(bsy1), .div_by_zero_out(dbz1));
    div_iter_multi #(.WIDTH(32), .STEP(4)) u2 (
        .clk(clk), .rst(rst), .signed_div_in(sgn[2]), .opdata1_in(op1[2]),
        .opdata2_in(op2[2]), .start_in(st[2]), .annul_in(an[2]), .result_out(res2),
        .ready_out(rdy2), .busy_out(bsy2), .div_by_zero_out(dbz2));

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb0[$], sb1[$], sb2[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [63:0] g_res(int d);
        case (d)
            0: return res0;
            1: return {32'd0, res1};
            default: return res2;
        endcase
    endfunction
    function automatic logic g_rdy(int d);
        case (d) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
    endfunction
    function automatic logic g_bsy(int d);
        case (d) 0: return bsy0; 1: return bsy1; default: return bsy2; endcase
    endfunction
    function automatic logic g_dbz(int d);
        case (d) 0: return dbz0; 1: return dbz1; default: return dbz2; endcase
    endfunction

    task automatic sb_push(int d, exp_t e);
        case (d) 0: sb0.push_back(e); 1: sb1.push_back(e); default: sb2.push_back(e); endcase
    endtask
    function automatic int sb_size(int d);
        case (d) 0: return sb0.size(); 1: return sb1.size(); default: return sb2.size(); endcase
    endfunction
    function automatic exp_t sb_pop(int d);
        case (d) 0: return sb0.pop_front(); 1: return sb1.pop_front(); default: return sb2.pop_front(); endcase
    endfunction

    task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    endtask

    // Reference: widen to 64 bits and use native division, which truncates
    // toward zero with the remainder taking the dividend's sign.
    function automatic logic [63:0] ref_div(int w, logic s, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, q, r;
        if (w == 16) begin
            ea = s ? {{48{a[15]}}, a[15:0]} : {48'd0, a[15:0]};
            eb = s ? {{48{b[15]}}, b[15:0]} : {48'd0, b[15:0]};
        end else begin
            ea = s ? {{32{a[31]}}, a} : {32'd0, a};
            eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        end
        if (eb == 64'd0) return 64'd0;
        q = $signed(ea) / $signed(eb);
        r = $signed(ea) % $signed(eb);
        if (w == 16) return {32'd0, r[15:0], q[15:0]};
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: compare on each rising ready, check clearing on each fall.
    logic rdy_p [3];
    exp_t me;
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (g_rdy(d) === 1'b1 && rdy_p[d] !== 1'b1) begin
                if (sb_size(d) == 0) begin
                    chk("unexpected_ready", d, 64'd1, 64'd0);
                end else begin
                    me = sb_pop(d);
                    chk("result", d, g_res(d), me.res);
                    chk("div_by_zero", d, {63'd0, g_dbz(d)}, {63'd0, me.dbz});
                    chk("latency", d, 64'(cyc - me.t0), 64'(me.lat));
                end
            end else if (g_rdy(d) === 1'b0 && rdy_p[d] === 1'b1) begin
                chk("clear_result", d, g_res(d), 64'd0);
                chk("clear_dbz", d, {63'd0, g_dbz(d)}, 64'd0);
            end
            rdy_p[d] <= g_rdy(d);
        end
    end

    task automatic run(int d, logic s, logic [31:0] a, logic [31:0] b,
                       logic [63:0] er, logic ed, int el, bit chg);
        exp_t e;
        bit   seen;
        @(negedge clk);
        sgn[d] = s; op1[d] = a; op2[d] = b; st[d] = 1'b1;
        e.res = er; e.dbz = ed; e.lat = el; e.t0 = cyc + 1;
        sb_push(d, e);
        if (chg) begin
            @(negedge clk);
            sgn[d] = ~s; op1[d] = ~a; op2[d] = b + 32'd3;
        end
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = (g_rdy(d) === 1'b1);
        end
        if (!seen) begin
            chk("ready_timeout", d, 64'd0, 64'd1);
            if (sb_size(d) != 0) void'(sb_pop(d));
        end else begin
            @(negedge clk);
            chk("ready_hold", d, {63'd0, g_rdy(d)}, 64'd1);
        end
        st[d] = 1'b0;
        @(negedge clk);
        chk("ready_drop", d, {63'd0, g_rdy(d)}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          w, lat;
        for (int d = 0; d < 3; d++) begin
            sgn[d] = 0; st[d] = 0; an[d] = 0; op1[d] = 0; op2[d] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_result", d, g_res(d), 64'd0);
            chk("reset_ready", d, {63'd0, g_rdy(d)}, 64'd0);
            chk("reset_busy", d, {63'd0, g_bsy(d)}, 64'd0);
            chk("reset_dbz", d, {63'd0, g_dbz(d)}, 64'd0);
        end
        rst = 1'b0;

        // 32/1 directed
        run(0, 0, 32'd100, 32'd7, 64'h00000002_0000000E, 0, 34, 0);
        run(0, 1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0, 34, 1);
        run(0, 1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0, 34, 1);
        run(0, 1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0, 34, 0);
        run(0, 0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 0, 34, 0);
        run(0, 0, 32'd100, 32'd0, 64'd0, 1, 2, 0);

        // annul 10 cycles into ON: no result, block returns to FREE
        @(negedge clk);
        sgn[0] = 0; op1[0] = 32'd100; op2[0] = 32'd7; st[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("busy_in_on", 0, {63'd0, bsy0}, 64'd1);
        an[0] = 1'b1; st[0] = 1'b0;
        @(negedge clk);
        an[0] = 1'b0;
        chk("annul_busy", 0, {63'd0, bsy0}, 64'd0);
        repeat (40) @(negedge clk);
        chk("annul_no_ready", 0, {63'd0, rdy0}, 64'd0);
        run(0, 0, 32'd100, 32'd7, 64'h00000002_0000000E, 0, 34, 0);

        // 16/2 directed
        run(1, 0, 32'd1000, 32'd3, 64'h00000000_0001014D, 0, 10, 0);
        run(1, 1, 32'h0000FFF9, 32'd2, 64'h00000000_FFFFFFFD, 0, 10, 1);
        run(1, 1, 32'h00008000, 32'h0000FFFF, 64'h00000000_00008000, 0, 10, 0);

        // reset mid-ON on 32/4
        @(negedge clk);
        sgn[2] = 0; op1[2] = 32'd100; op2[2] = 32'd7; st[2] = 1'b1;
        repeat (4) @(negedge clk);
        chk("busy_before_rst", 2, {63'd0, bsy2}, 64'd1);
        rst = 1'b1; st[2] = 1'b0;
        @(negedge clk);
        chk("rst_result", 2, res2, 64'd0);
        chk("rst_ready", 2, {63'd0, rdy2}, 64'd0);
        chk("rst_busy", 2, {63'd0, bsy2}, 64'd0);
        chk("rst_dbz", 2, {63'd0, dbz2}, 64'd0);
        rst = 1'b0;
        run(2, 0, 32'd100, 32'd7, 64'h00000002_0000000E, 0, 10, 0);

        // random regression against the reference model
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 8; k++) begin
                w = (d == 1) ? 16 : 32;
                s = 1'($urandom_range(0, 1));
                a = $urandom;
                case (k % 4)
                    0: b = 32'd0;
                    1: b = $urandom_range(1, 300);
                    2: b = 32'hFFFFFFFF - $urandom_range(0, 5);
                    default: b = $urandom;
                endcase
                if (w == 16) begin
                    a = {16'd0, a[15:0]};
                    b = {16'd0, b[15:0]};
                end
                lat = (b == 32'd0) ? 2 : ((d == 0) ? 34 : 10);
                run(d, s, a, b, ref_div(w, s, a, b), (b == 32'd0), lat, 0);
            end
        end

        repeat (5) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk("scoreboard_empty", d, 64'(sb_size(d)), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
